// File: rtl/vga_line_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_line_prefetch_if
// Description : Read-only framebuffer port used by the line prefetcher.
//               A request is held (mem_req, mem_addr) until mem_ack; data
//               is returned in the same cycle as the ack.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_line_prefetch_if #(
  parameter int ADDR_WIDTH = 20
) ();

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_data;

  // Prefetcher side: issues requests, consumes data
  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  // Memory side: accepts requests, returns data
  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );

endinterface
`default_nettype wire

// File: rtl/vga_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : vga_line_prefetch
// Description : Ping-pong line buffer in front of the VGA generator. While
//               one half is displayed, the next line is fetched from the
//               framebuffer into the other half. A sticky underrun flag
//               reports aborted fetches and lines displayed before they
//               were completely fetched.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_line_prefetch #(
  parameter int          RES_X      = 640,
  parameter int          RES_Y      = 480,
  parameter int          ADDR_WIDTH = 20,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 COL,
  input  logic [8:0]                 LINE,
  input  logic                       inDisplayArea,
  input  logic                       frame_start,
  output logic [31:0]                pixel,
  vga_line_prefetch_if.master        mem,
  output logic                       underrun,
  input  logic                       underrun_clr
);

  localparam int IDX_W = (RES_X > 1) ? $clog2(RES_X) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RES_X - 1);
  // Upper byte of every displayed word is forced to zero
  localparam logic [31:0] PIX_MASK = 32'h00FF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        target_q, target_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        valid_q, valid_d;
  logic              underrun_q, underrun_d;
  logic [31:0]       pixel_q, pixel_d;

  // Two line halves; half index is bit 0 of the line number
  logic [31:0]       line_buf [2][RES_X];

  logic              trig;
  logic [8:0]        trig_line;
  logic              fetch_abort;
  logic              display_miss;
  logic              wr_en;
  logic              wr_sel;
  logic [IDX_W-1:0]  wr_idx;
  logic [31:0]       wr_data;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       rd_word;
  logic [ADDR_WIDTH-1:0] fetch_addr;

  // Fetch triggers: frame_start targets line 0; end of active video on a line
  // that has a successor targets the next line. frame_start wins on overlap.
  always_comb begin
    trig      = 1'b0;
    trig_line = 9'd0;
    if (frame_start) begin
      trig      = 1'b1;
      trig_line = 9'd0;
    end else if ((int'(COL) == RES_X) && ((int'(LINE) + 1) < RES_Y)) begin
      trig      = 1'b1;
      trig_line = LINE + 9'd1;
    end
  end

  // Framebuffer word address, computed modulo 2^ADDR_WIDTH
  always_comb begin
    fetch_addr = ADDR_WIDTH'(BASE_ADDR)
               + ADDR_WIDTH'(target_q) * ADDR_WIDTH'(RES_X)
               + ADDR_WIDTH'(idx_q);
  end

  assign mem.mem_req  = (state_q == ST_FETCH);
  assign mem.mem_addr = (state_q == ST_FETCH) ? fetch_addr : '0;

  // Fetch FSM next state, buffer write strobe and valid bookkeeping
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    wr_en       = 1'b0;
    wr_sel      = target_q[0];
    wr_idx      = idx_q;
    wr_data     = mem.mem_data;
    fetch_abort = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // An ack that coincides with a new trigger belongs to the fetch being
        // abandoned, so it is dropped rather than written.
        if (mem.mem_ack && !trig) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        valid_d[target_q[0]] = 1'b1;
        state_d              = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A trigger restarts from word 0 regardless of state; the target half is
    // invalidated so it cannot be displayed half-written.
    if (trig) begin
      if (state_q == ST_FETCH) begin
        fetch_abort = 1'b1;
      end
      target_d              = trig_line;
      valid_d[trig_line[0]] = 1'b0;
      idx_d                 = '0;
      state_d               = ST_FETCH;
    end
  end

  // Display read path: out-of-range columns read word 0 to keep the index legal
  always_comb begin
    rd_idx       = (int'(COL) < RES_X) ? COL[IDX_W-1:0] : '0;
    rd_word      = line_buf[LINE[0]][rd_idx];
    pixel_d      = 32'd0;
    display_miss = 1'b0;
    if (inDisplayArea) begin
      if (valid_q[LINE[0]]) begin
        pixel_d = rd_word & PIX_MASK;
      end else begin
        display_miss = 1'b1;
      end
    end
  end

  // Sticky underrun: a new error event wins over a simultaneous clear
  always_comb begin
    underrun_d = underrun_q;
    if (underrun_clr) begin
      underrun_d = 1'b0;
    end
    if (fetch_abort || display_miss) begin
      underrun_d = 1'b1;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      target_q   <= 9'd0;
      idx_q      <= '0;
      valid_q    <= 2'b00;
      underrun_q <= 1'b0;
      pixel_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      pixel_q    <= pixel_d;
    end
  end

  // Line buffer storage; same-cycle read of a written word sees old data
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_buf[wr_sel][wr_idx] <= wr_data;
    end
  end

  assign pixel    = pixel_q;
  assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_line_prefetch
// Description : Directed bench for vga_line_prefetch. Expected request
//               addresses and displayed pixels are queued by the stimulus;
//               a monitor pops and compares them as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_line_prefetch;

  localparam int          RES_X = 640;
  localparam int          RES_Y = 480;
  localparam int          AW    = 20;
  localparam int unsigned BASE  = 32'h000F_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  col = 10'd0;
  logic [8:0]  line = 9'd0;
  logic        disp = 1'b0;
  logic        fs = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] pixel;
  logic        underrun;

  vga_line_prefetch_if #(.ADDR_WIDTH(AW)) mem_if ();

  vga_line_prefetch #(
    .RES_X      (RES_X),
    .RES_Y      (RES_Y),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .COL           (col),
    .LINE          (line),
    .inDisplayArea (disp),
    .frame_start   (fs),
    .pixel         (pixel),
    .mem           (mem_if.master),
    .underrun      (underrun),
    .underrun_clr  (clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat    = 0;

  logic [AW-1:0] addr_q [$];
  logic [31:0]   pix_q  [$];
  logic          pix_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int ln, input int c);
    logic [31:0] a;
    a = BASE + 32'(ln * RES_X + c);
    return a[AW-1:0];
  endfunction

  function automatic logic [31:0] exp_pix(input int ln, input int c);
    return {12'h000, exp_addr(ln, c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input int ln);
    for (int i = 0; i < RES_X; i++) addr_q.push_back(exp_addr(ln, i));
  endtask

  task automatic show(input int ln, input int c, input logic [31:0] exp);
    line = 9'(ln);
    col  = 10'(c);
    disp = 1'b1;
    pix_q.push_back(exp);
    tick();
    disp = 1'b0;
    col  = 10'd0;
  endtask

  task automatic line_trig(input int ln);
    line = 9'(ln);
    col  = 10'(RES_X);
    tick();
    col  = 10'd0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (addr_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (addr_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d requests still outstanding after %0d cycles, required 0", name, addr_q.size(), budget);
      addr_q.delete();
    end
  endtask

  // Framebuffer model: data word is the address with a nonzero top byte.
  // lat = number of wait cycles before each ack; lat 0 acks every cycle,
  // including cycles with no request.
  initial begin
    int cnt;
    cnt = 0;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_data = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (lat == 0) begin
        mem_if.mem_ack = 1'b1;
        cnt = 0;
      end else if (!mem_if.mem_req) begin
        mem_if.mem_ack = 1'b0;
        cnt = 0;
      end else if (cnt >= lat) begin
        mem_if.mem_ack = 1'b1;
        cnt = 0;
      end else begin
        mem_if.mem_ack = 1'b0;
        cnt++;
      end
      mem_if.mem_data = {8'hA5, 4'h0, mem_if.mem_addr};
    end
  end

  always @(posedge clk) pix_pending <= disp && !rst;

  // Monitor: every presented request address and every pixel output
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_if.mem_req) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h, required no request", mem_if.mem_addr);
        end else begin
          check("mem_addr", 32'(mem_if.mem_addr), 32'(addr_q[0]));
          if (mem_if.mem_ack) void'(addr_q.pop_front());
        end
      end
      if (pix_pending) begin
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_queue: got pixel %h with nothing expected", pixel);
        end else begin
          check("pixel", pixel, pix_q.pop_front());
        end
      end else begin
        check("pixel_blank", pixel, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst_pixel",    pixel, 32'd0);
    check("rst_mem_req",  32'(mem_if.mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_valid",    32'(dut.valid_q), 32'd0);
    rst = 1'b0;
    tick();

    // Zero-wait memory, line 0 from frame_start
    lat = 0;
    push_line(0);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    check("req_one_cycle_after_trigger", 32'(mem_if.mem_req), 32'd1);
    drain("line0_zero_wait", 700);
    tick();
    tick();
    check("valid_after_line0", 32'(dut.valid_q), 32'd1);
    show(0, 5, exp_pix(0, 5));
    show(0, 639, exp_pix(0, 639));
    show(0, 0, exp_pix(0, 0));
    check("underrun_line0", 32'(underrun), 32'd0);

    // Two wait cycles per word, line 1 from end of line 0
    lat = 2;
    push_line(1);
    line_trig(0);
    drain("line1_wait2", 2100);
    tick();
    tick();
    check("valid_after_line1", 32'(dut.valid_q), 32'd3);
    show(1, 7, exp_pix(1, 7));
    show(1, 320, exp_pix(1, 320));
    check("underrun_line1", 32'(underrun), 32'd0);

    // Slow memory: line 1 displayed before its refetch completes
    lat = 5;
    push_line(1);
    line_trig(0);
    repeat (50) tick();
    check("valid1_cleared", 32'(dut.valid_q), 32'd1);
    show(1, 3, 32'd0);
    check("underrun_on_miss", 32'(underrun), 32'd1);
    repeat (20) tick();
    check("underrun_sticky", 32'(underrun), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("underrun_cleared", 32'(underrun), 32'd0);

    // frame_start during an active fetch aborts it and restarts at line 0
    lat = 0;
    repeat (20) tick();
    fs = 1'b1;
    tick();
    fs = 1'b0;
    addr_q.delete();
    push_line(0);
    check("underrun_on_abort", 32'(underrun), 32'd1);
    drain("line0_after_abort", 700);
    tick();
    tick();
    check("valid_after_abort", 32'(dut.valid_q), 32'd1);
    show(0, 9, exp_pix(0, 9));

    // Clear and a miss in the same cycle: set wins
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("underrun_clr2", 32'(underrun), 32'd0);
    line = 9'd1;
    col  = 10'd0;
    disp = 1'b1;
    clr  = 1'b1;
    pix_q.push_back(32'd0);
    tick();
    disp = 1'b0;
    clr  = 1'b0;
    check("underrun_set_over_clr", 32'(underrun), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Last line: address wraps within ADDR_WIDTH bits
    push_line(479);
    line_trig(478);
    drain("line479_wrap", 700);
    tick();
    tick();
    check("valid_after_line479", 32'(dut.valid_q), 32'd3);
    show(479, 2, exp_pix(479, 2));
    show(479, 639, exp_pix(479, 639));
    check("underrun_line479", 32'(underrun), 32'd0);

    // End of line 479 has no successor: no fetch
    line_trig(479);
    repeat (10) tick();
    check("no_fetch_after_479", 32'(mem_if.mem_req), 32'd0);
    check("valid_kept_after_479", 32'(dut.valid_q), 32'd3);

    // Reset in the middle of a fetch
    lat = 0;
    push_line(0);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    begin
      int n;
      n = 0;
      while (addr_q.size() > RES_X - 300 && n < 400) begin
        tick();
        n++;
      end
      check("reached_idx300", 32'(addr_q.size()), 32'(RES_X - 300));
    end
    rst = 1'b1;
    addr_q.delete();
    tick();
    check("rst_mid_mem_req",  32'(mem_if.mem_req), 32'd0);
    check("rst_mid_pixel",    pixel, 32'd0);
    check("rst_mid_valid",    32'(dut.valid_q), 32'd0);
    check("rst_mid_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("idle_after_rst", 32'(mem_if.mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
